// File: rtl/prf_free_list.sv
// prf_free_list
//   Circular FIFO of free physical register tags. Rename takes up to WAYS
//   tags per cycle from the speculative head; retirement returns displaced
//   tags at the tail and advances the architectural head; a flush rewinds
//   the speculative head to the architectural head.
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high; list refilled with tags ARF..PRF-1
//   except      flush: speculative allocations are returned, alloc ignored
//   alloc_req   per-lane request for a destination tag
//   alloc_tag   per-lane granted tag (meaningful when alloc_ok & alloc_req[i])
//   alloc_ok    whole request granted (all-or-nothing)
//   commit_en   per-lane retirement with a destination
//   commit_old  per-lane tag displaced from the RRAT, returned to the list
//   free_count  speculative free entries (tail - head)
module prf_free_list #(
  parameter  int WAYS = 4,
  parameter  int PRF  = 64,
  parameter  int ARF  = 32,
  localparam int TW   = $clog2(PRF),
  localparam int FL   = PRF - ARF,
  localparam int LW   = $clog2(FL),
  localparam int PW   = LW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               except,
  input  logic [WAYS-1:0]    alloc_req,
  output logic [WAYS*TW-1:0] alloc_tag,
  output logic               alloc_ok,
  input  logic [WAYS-1:0]    commit_en,
  input  logic [WAYS*TW-1:0] commit_old,
  output logic [PW-1:0]      free_count
);

  logic [TW-1:0] mem [FL];
  logic [PW-1:0] head;
  logic [PW-1:0] arch_head;
  logic [PW-1:0] tail;

  logic [PW-1:0] alloc_n;
  logic [PW-1:0] commit_n;
  logic [LW-1:0] wr_idx [WAYS];

  // Pointers carry an extra wrap bit, so the difference is the occupancy
  // even when tail has wrapped past head.
  always_comb begin
    free_count = tail - head;
  end

  // Each requesting lane reads the entry offset by the number of requesting
  // lanes below it; non-requesting lanes just mirror the next entry.
  always_comb begin
    alloc_tag = '0;
    alloc_n   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      alloc_tag[i*TW +: TW] = mem[LW'(head + alloc_n)];
      alloc_n = alloc_n + PW'(alloc_req[i]);
    end
    alloc_ok = (alloc_n <= free_count) & ~except & ~reset;
  end

  // Enabled commit lanes pack into consecutive slots starting at tail.
  always_comb begin
    commit_n = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      wr_idx[i] = LW'(tail + commit_n);
      commit_n  = commit_n + PW'(commit_en[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL; i++) begin
        mem[i] <= TW'(ARF + i);
      end
      head      <= '0;
      arch_head <= '0;
      tail      <= PW'(FL);
    end else begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (commit_en[i]) begin
          mem[wr_idx[i]] <= commit_old[i*TW +: TW];
        end
      end
      tail      <= tail + commit_n;
      arch_head <= arch_head + commit_n;
      // Flush rewinds to the architectural head including this cycle's
      // retirements; otherwise a granted request advances the head.
      if (except) begin
        head <= arch_head + commit_n;
      end else if (alloc_ok) begin
        head <= head + alloc_n;
      end
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
// tb_prf_free_list
//   Scoreboard bench for prf_free_list (WAYS=4, PRF=64, ARF=32). A queue-based
//   model holds the entries between the architectural head and the tail plus
//   a count of speculatively granted entries; expected grants are queued as
//   stimulus is driven and compared against the sampled DUT outputs.
module tb_prf_free_list;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        except = 1'b0;
  logic [3:0]  alloc_req = '0;
  logic [23:0] alloc_tag;
  logic        alloc_ok;
  logic [3:0]  commit_en = '0;
  logic [23:0] commit_old = '0;
  logic [5:0]  free_count;

  prf_free_list #(.WAYS(4), .PRF(64), .ARF(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .except     (except),
    .alloc_req  (alloc_req),
    .alloc_tag  (alloc_tag),
    .alloc_ok   (alloc_ok),
    .commit_en  (commit_en),
    .commit_old (commit_old),
    .free_count (free_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic            ok;
    logic [5:0]      fc;
    logic [3:0][5:0] tags;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   fl[$];    // entries from arch head to tail, oldest first
  int   ownq[$];  // tags held architecturally (not in the list)
  int   spec;     // entries of fl already granted speculatively
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void model_init();
    fl.delete();
    ownq.delete();
    for (int i = 0; i < 32; i++) begin
      fl.push_back(32 + i);
      ownq.push_back(i);
    end
    spec = 0;
  endfunction

  function automatic void own_remove(input int t);
    for (int i = 0; i < ownq.size(); i++) begin
      if (ownq[i] == t) begin
        ownq.delete(i);
        return;
      end
    end
  endfunction

  function automatic bit is_owned(input int t);
    foreach (ownq[i]) if (ownq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: apply inputs after the edge, queue the expected grant, sample
  // at the falling edge, then advance the model to match the next edge.
  task automatic drive(input logic [3:0] rq, input logic [3:0] cen,
                       input logic [23:0] cold, input logic exc, input logic rst);
    rec_t e, o;
    int n, fcm, k;
    alloc_req = rq; commit_en = cen; commit_old = cold; except = exc; reset = rst;
    n   = $countones(rq);
    fcm = fl.size() - spec;
    e    = '0;
    e.fc = 6'(fcm);
    e.ok = (n <= fcm) && !exc && !rst;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (rq[i]) begin
        if (e.ok) e.tags[i] = 6'(fl[spec + k]);
        k++;
      end
    end
    exp_q.push_back(e);
    @(negedge clock);
    o    = '0;
    o.ok = alloc_ok;
    o.fc = free_count;
    for (int i = 0; i < 4; i++) if (rq[i] && e.ok) o.tags[i] = alloc_tag[i*6 +: 6];
    obs_q.push_back(o);
    if (rst) begin
      model_init();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cen[i]) begin
          own_remove(int'(cold[i*6 +: 6]));
          ownq.push_back(fl.pop_front());
          fl.push_back(int'(cold[i*6 +: 6]));
          spec--;
        end
      end
      if (e.ok) spec += n;
      if (exc) spec = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rec_t e, o;
    reset = 1'b1; alloc_req = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (free_count !== 6'd32) begin
      n_fail++; $display("FAIL reset_free_count: got %0d, expected 32", free_count);
    end
    n_checks++;
    if (alloc_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_alloc_ok: got %b, expected 0", alloc_ok);
    end
    model_init();
    drive(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_reset: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
    end
  endtask

  task automatic test_alloc();
    rec_t e, o;
    drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b1 || o.tags !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
      n_fail++; $display("FAIL alloc_1111: got ok=%b tags=%h, expected ok=1 tags=%h",
                         o.ok, o.tags, {6'd35, 6'd34, 6'd33, 6'd32});
    end
    n_checks++;
    if (free_count !== 6'd28) begin
      n_fail++; $display("FAIL alloc_fc28: got %0d, expected 28", free_count);
    end
    drive(4'b1010, 4'b0000, '0, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b1 || o.tags[1] !== 6'd36 || o.tags[3] !== 6'd37) begin
      n_fail++; $display("FAIL alloc_1010: got ok=%b lane1=%0d lane3=%0d, expected ok=1 lane1=36 lane3=37",
                         o.ok, o.tags[1], o.tags[3]);
    end
    n_checks++;
    if (free_count !== 6'd26) begin
      n_fail++; $display("FAIL alloc_fc26: got %0d, expected 26", free_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_alloc: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
    end
  endtask

  task automatic test_stall();
    rec_t e, o;
    repeat (6) drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    drive(4'b0111, 4'b0001, {18'd0, 6'd5}, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b0 || o.fc !== 6'd2) begin
      n_fail++; $display("FAIL stall_0111: got ok=%b fc=%0d, expected ok=0 fc=2", o.ok, o.fc);
    end
    n_checks++;
    if (free_count !== 6'd3) begin
      n_fail++; $display("FAIL stall_fc3: got %0d, expected 3", free_count);
    end
    drive(4'b0111, 4'b0000, '0, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b1 || o.tags[0] !== 6'd62 || o.tags[1] !== 6'd63 || o.tags[2] !== 6'd5) begin
      n_fail++; $display("FAIL stall_retry: got ok=%b tags=%0d,%0d,%0d, expected ok=1 tags=62,63,5",
                         o.ok, o.tags[0], o.tags[1], o.tags[2]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_stall: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
    end
  endtask

  task automatic test_except();
    rec_t e, o;
    drive(4'b0000, 4'b0000, '0, 1'b0, 1'b1);
    drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    drive(4'b0011, 4'b0000, '0, 1'b0, 1'b0);
    drive(4'b0000, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, 1'b0, 1'b0);
    drive(4'b1111, 4'b0001, {18'd0, 6'd4}, 1'b1, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b0) begin
      n_fail++; $display("FAIL except_ok: got %b, expected 0", o.ok);
    end
    n_checks++;
    if (free_count !== 6'd32) begin
      n_fail++; $display("FAIL except_fc: got %0d, expected 32", free_count);
    end
    drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b1 || o.tags !== {6'd39, 6'd38, 6'd37, 6'd36}) begin
      n_fail++; $display("FAIL except_realloc: got ok=%b tags=%h, expected ok=1 tags=%h",
                         o.ok, o.tags, {6'd39, 6'd38, 6'd37, 6'd36});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_except: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
    end
  endtask

  task automatic random_cycle(output logic [3:0] rq, input logic exc_ok);
    logic [3:0]  cen;
    logic [23:0] cold;
    logic        exc;
    int          k;
    rq  = 4'($urandom);
    cen = 4'($urandom);
    for (int i = 3; i >= 0; i--) if ($countones(cen) > spec) cen[i] = 1'b0;
    cold = '0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (cen[i]) begin
        cold[i*6 +: 6] = 6'(ownq[k]);
        k++;
      end
    end
    exc = exc_ok && ($urandom_range(0, 15) == 0);
    drive(rq, cen, cold, exc, 1'b0);
  endtask

  task automatic test_random();
    rec_t e, o;
    logic [3:0] rq;
    for (int cyc = 0; cyc < 200; cyc++) begin
      random_cycle(rq, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_random cycle %0d: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 cyc, o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
      if (o.ok) begin
        for (int i = 0; i < 4; i++) begin
          if (rq[i]) begin
            n_checks++;
            if (is_owned(int'(o.tags[i]))) begin
              n_fail++;
              $display("FAIL random_live cycle %0d lane %0d: got tag %0d, required a tag not live", cyc, i, o.tags[i]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    logic [3:0] rq;
    repeat (5) random_cycle(rq, 1'b0);
    drive(4'b1111, 4'b0011, {12'd0, 6'(ownq[1]), 6'(ownq[0])}, 1'b1, 1'b1);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ok: got %b, expected 0", o.ok);
    end
    drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
    o = obs_q[obs_q.size()-1];
    n_checks++;
    if (o.fc !== 6'd32 || o.ok !== 1'b1 || o.tags !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
      n_fail++; $display("FAIL reset_mid_state: got ok=%b fc=%0d tags=%h, expected ok=1 fc=32 tags=%h",
                         o.ok, o.fc, o.tags, {6'd35, 6'd34, 6'd33, 6'd32});
    end
    n_checks++;
    if (free_count !== 6'd28) begin
      n_fail++; $display("FAIL reset_mid_fc28: got %0d, expected 28", free_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL test_reset_mid: got ok=%b fc=%0d tags=%h, expected ok=%b fc=%0d tags=%h",
                 o.ok, o.fc, o.tags, e.ok, e.fc, e.tags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_stall();
    test_except();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
